// File: rtl/ecc_arith_pkg.sv
// Shared types and constants for the ECC coprocessor modular arithmetic units
// (add, sub, mul).
package ecc_arith_pkg;

    localparam int unsigned ECC_WIDTH = 64;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    typedef enum logic [1:0] {
        ADD_IDLE = 2'd0,
        ADD_CALC = 2'd1,
        ADD_DONE = 2'd2
    } add_state_e;

    typedef enum logic [1:0] {
        SUB_IDLE = 2'd0,
        SUB_CALC = 2'd1,
        SUB_DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/mul_modular_step.sv
// One double-and-add iteration: acc_next = (2*acc + (b_bit ? a : 0)) mod p.
// Intermediates carry one extra bit so moduli close to 2^WIDTH work.
module mul_modular_step
    import ecc_arith_pkg::*;
#(
    parameter int unsigned WIDTH = ECC_WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] p,
    input  logic             b_bit,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH:0] p_ext;
    logic [WIDTH:0] dbl;
    logic [WIDTH:0] t;
    logic [WIDTH:0] u_sum;

    always_comb begin
        p_ext = {1'b0, p};
        dbl   = {acc, 1'b0};
        t     = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
        u_sum = t + (b_bit ? {1'b0, a} : '0);
        acc_next = (u_sum >= p_ext) ? WIDTH'(u_sum - p_ext) : u_sum[WIDTH-1:0];
    end

endmodule

// File: rtl/mul_modular_unit.sv
// Iterative modular multiplier (a*b mod p), MSB-first interleaved double-and-add.
// Optional MUL_MODULAR_EARLY_EXIT_EN: skip leading zero bits of b and trivial operands.
module mul_modular_unit
    import ecc_arith_pkg::*;
#(
    parameter int unsigned WIDTH = ECC_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] p_i,
    input  logic             mul_start_i,
    output logic [WIDTH-1:0] mul_result_o,
    output logic             mul_finish_o,
    output logic             mul_busy_o
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] result_d;
    logic             finish_d;
    logic             busy_d;
    logic [WIDTH-1:0] step_acc;

    mul_modular_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc_q),
        .a        (a_q),
        .p        (p_q),
        .b_bit    (b_q[idx_q]),
        .acc_next (step_acc)
    );

`ifdef MUL_MODULAR_EARLY_EXIT_EN
    logic [IDX_W-1:0] msb_idx;
    logic             trivial_op;

    // Priority encoder: index of the highest set bit of b_i.
    always_comb begin
        msb_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (b_i[i]) begin
                msb_idx = IDX_W'(i);
            end
        end
        trivial_op = (a_i == '0) || (b_i == '0) || (p_i <= WIDTH'(1));
    end
`endif

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = mul_result_o;
        finish_d = 1'b0;
        busy_d   = 1'b0;

        case (state_q)
            MUL_IDLE, MUL_DONE: begin
                state_d = MUL_IDLE;
                if (mul_start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    p_d     = p_i;
                    acc_d   = '0;
                    idx_d   = IDX_W'(WIDTH - 1);
                    state_d = MUL_RUN;
                    busy_d  = 1'b1;
`ifdef MUL_MODULAR_EARLY_EXIT_EN
                    if (trivial_op) begin
                        state_d  = MUL_DONE;
                        result_d = '0;
                        finish_d = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        idx_d = msb_idx;
                    end
`endif
                end
            end
            MUL_RUN: begin
                busy_d = 1'b1;
                acc_d  = step_acc;
                if (idx_q == '0) begin
                    state_d  = MUL_DONE;
                    finish_d = 1'b1;
                    busy_d   = 1'b0;
                    // A modulus of 0 or 1 always reduces to 0.
                    result_d = (p_q <= WIDTH'(1)) ? '0 : step_acc;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= MUL_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            p_q          <= '0;
            acc_q        <= '0;
            idx_q        <= '0;
            mul_result_o <= '0;
            mul_finish_o <= 1'b0;
            mul_busy_o   <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            p_q          <= p_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            mul_result_o <= result_d;
            mul_finish_o <= finish_d;
            mul_busy_o   <= busy_d;
        end
    end

endmodule

// File: tb/tb_mul_modular_unit.sv
// Self-checking bench for mul_modular_unit: directed vectors, random operands
// against a big-integer reference, ignored starts, reset abort, back-to-back.
module tb_mul_modular_unit;

    localparam int unsigned W = 64;
    localparam int MAX_CYC = 300;

    logic         clk;
    logic         rst_ni;
    logic [W-1:0] a_i, b_i, p_i;
    logic         mul_start_i;
    logic [W-1:0] mul_result_o;
    logic         mul_finish_o;
    logic         mul_busy_o;

    int errors = 0;
    int checks = 0;

    mul_modular_unit #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .a_i          (a_i),
        .b_i          (b_i),
        .p_i          (p_i),
        .mul_start_i  (mul_start_i),
        .mul_result_o (mul_result_o),
        .mul_finish_o (mul_finish_o),
        .mul_busy_o   (mul_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Reference: plain wide arithmetic.
    function automatic logic [W-1:0] ref_mul(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] p);
        logic [2*W-1:0] prod;
        if (p <= 1) return '0;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        prod = prod % {{W{1'b0}}, p};
        return prod[W-1:0];
    endfunction

    // Cycles from the start cycle to the finish cycle.
    function automatic int exp_lat(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] p);
`ifdef MUL_MODULAR_EARLY_EXIT_EN
        if (a == 0 || b == 0 || p <= 1) return 1;
        for (int i = W - 1; i >= 0; i--) if (b[i]) return i + 2;
        return 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p);
        a_i = a; b_i = b; p_i = p;
        mul_start_i = 1'b1;
        @(posedge clk); #1;
    endtask

    // Observe an accepted op; scrambles inputs while it runs, optionally pokes a start.
    task automatic measure(input int poke, input int extra, output logic [W-1:0] res,
                           output int lat, output int busy_cnt, output int fin_cnt);
        res = '0; lat = 0; busy_cnt = 0; fin_cnt = 0;
        for (int k = 1; k <= MAX_CYC; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            if (mul_finish_o) begin
                fin_cnt++;
                if (lat == 0) begin lat = k; res = mul_result_o; end
            end
            if (mul_busy_o) busy_cnt++;
            if (lat != 0 && k >= lat + extra) break;
            if (k == poke) begin
                a_i = 1; b_i = 1; mul_start_i = 1'b1;
            end else begin
                mul_start_i = 1'b0;
                a_i = rand64(); b_i = rand64(); p_i = rand64();
            end
        end
        mul_start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; mul_start_i = 1'b0; a_i = '0; b_i = '0; p_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (mul_result_o !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", mul_result_o); end
        checks++; if (mul_finish_o !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b exp=0", mul_finish_o); end
        checks++; if (mul_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", mul_busy_o); end
        @(negedge clk); rst_ni = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [10];
        logic [W-1:0] tb [10];
        logic [W-1:0] tp [10];
        logic [W-1:0] te [10];
        logic [W-1:0] res;
        int lat, bc, fc, el;
        ta[0] = 45;                    tb[0] = 71;             tp[0] = 97;                    te[0] = 91;
        ta[1] = 64'h1000000000000000;  tb[1] = 4;              tp[1] = 64'h1FFFFFFFFFFFFFFF;  te[1] = 2;
        ta[2] = 64'hFFFFFFFFFFFFFFC4;  tb[2] = ta[2];          tp[2] = 64'hFFFFFFFFFFFFFFC5;  te[2] = 1;
        ta[3] = 5;                     tb[3] = 7;              tp[3] = 13;                    te[3] = 9;
        ta[4] = 123;                   tb[4] = 456;            tp[4] = 0;                     te[4] = 0;
        ta[5] = 0;                     tb[5] = 0;              tp[5] = 1;                     te[5] = 0;
        ta[6] = 0;                     tb[6] = 55;             tp[6] = 97;                    te[6] = 0;
        ta[7] = 96;                    tb[7] = 96;             tp[7] = 97;                    te[7] = 1;
        ta[8] = 45;                    tb[8] = 3;              tp[8] = 97;                    te[8] = 38;
        ta[9] = 1;                     tb[9] = 64'h8000000000000000; tp[9] = 64'hFFFFFFFFFFFFFFC5; te[9] = 64'h8000000000000000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            el = exp_lat(ta[i], tb[i], tp[i]);
            do_start(ta[i], tb[i], tp[i]);
            measure(0, 2, res, lat, bc, fc);
            checks++; if (res !== te[i]) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, te[i]); end
            checks++; if (lat != el) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, el); end
            checks++; if (bc != el - 1) begin errors++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bc, el - 1); end
            checks++; if (fc != 1) begin errors++; $display("FAIL dir%0d_finish_pulses got=%0d exp=1", i, fc); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, p, res, er;
        int lat, bc, fc, el;
        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0: p = rand64();
                1: p = W'($urandom_range(2, 1000));
                2: p = {1'b1, rand64()} >> 1 | 64'h8000000000000000;
                default: p = W'($urandom_range(0, 1));
            endcase
            if (p > 1) begin a = rand64() % p; b = rand64() % p; end
            else begin a = rand64(); b = rand64(); end
            if (i == 5) b = 1;
            er = ref_mul(a, b, p);
            el = exp_lat(a, b, p);
            @(negedge clk);
            do_start(a, b, p);
            measure(0, 1, res, lat, bc, fc);
            checks++; if (res !== er) begin errors++; $display("FAIL rnd%0d_result a=%h b=%h p=%h got=%h exp=%h", i, a, b, p, res, er); end
            checks++; if (lat != el) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, el); end
            checks++; if (fc != 1) begin errors++; $display("FAIL rnd%0d_finish_pulses got=%0d exp=1", i, fc); end
        end
    endtask

    task automatic test_start_in_run();
        logic [W-1:0] res;
        int lat, bc, fc, el;
        el = exp_lat(45, 71, 97);
        @(negedge clk);
        do_start(45, 71, 97);
        measure(10, 70, res, lat, bc, fc);
        checks++; if (res !== 91) begin errors++; $display("FAIL ignored_start_result got=%h exp=%h", res, 64'd91); end
        checks++; if (lat != el) begin errors++; $display("FAIL ignored_start_latency got=%0d exp=%0d", lat, el); end
        checks++; if (fc != 1) begin errors++; $display("FAIL ignored_start_finish_pulses got=%0d exp=1", fc); end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] res;
        int lat, bc, fc, el;
        @(negedge clk);
        do_start(45, 71, 97);
        mul_start_i = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk); rst_ni = 1'b0;
        #1;
        checks++; if (mul_busy_o !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", mul_busy_o); end
        checks++; if (mul_result_o !== '0) begin errors++; $display("FAIL abort_result got=%h exp=0", mul_result_o); end
        @(negedge clk); rst_ni = 1'b1;
        fc = 0;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (mul_finish_o) fc++;
        end
        checks++; if (fc != 0) begin errors++; $display("FAIL abort_stray_finish got=%0d exp=0", fc); end
        el = exp_lat(5, 7, 13);
        @(negedge clk);
        do_start(5, 7, 13);
        measure(0, 1, res, lat, bc, fc);
        checks++; if (res !== 9) begin errors++; $display("FAIL after_abort_result got=%h exp=%h", res, 64'd9); end
        checks++; if (lat != el) begin errors++; $display("FAIL after_abort_latency got=%0d exp=%0d", lat, el); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res;
        int lat, bc, fc, el;
        @(negedge clk);
        do_start(45, 71, 97);
        measure(0, 0, res, lat, bc, fc);
        checks++; if (res !== 91) begin errors++; $display("FAIL b2b_first_result got=%h exp=%h", res, 64'd91); end
        // Still inside the finish cycle: this start is accepted at the next edge.
        el = exp_lat(5, 7, 13);
        do_start(5, 7, 13);
        measure(0, 2, res, lat, bc, fc);
        checks++; if (res !== 9) begin errors++; $display("FAIL b2b_second_result got=%h exp=%h", res, 64'd9); end
        checks++; if (lat != el) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, el); end
        checks++; if (fc != 1) begin errors++; $display("FAIL b2b_second_finish_pulses got=%0d exp=1", fc); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (mul_result_o !== 9) begin errors++; $display("FAIL hold_result got=%h exp=%h", mul_result_o, 64'd9); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_in_run();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
